stoch_carry_reinject: RTL and testbench
=======================================

Name: stoch_carry_reinject

Overview:
- Receiving end of the stochastic OR-adder carry interface.
- Consumes the OR-sum bit plus the thermometer-coded carry bus produced by a cascaded-OR adder.
- Banks the "lost" extra ones in a saturating pending counter and re-emits them as extra ones in later cycles where the OR-sum is 0. This restores the expected value of the stochastic sum.
- Sits directly after each OR-carry adder in the neuron datapath.

Parameters:
N_CARRY, 2, width of carry thermometer bus; bit n high means more than n+1 inputs were high
W_PEND, 4, pending-carry counter width; saturates at 2^W_PEND-1

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous reset, active-low
EN  input  1  cycle enable; same sense as adder EN
CLR  input  1  synchronous clear of counter, flags and output
OR_IN  input  1  stochastic OR-sum bit from the adder
CARRY_IN  input  N_CARRY  thermometer carry bus from the adder
OUT  output  1  registered corrected stochastic bit
PENDING  output  W_PEND  current pending-carry count (registered)
EMPTY  output  1  PENDING==0 (combinational from register)
SAT  output  1  sticky: a carry was dropped due to saturation
ERR  output  1  one-cycle pulse: CARRY_IN was not a valid thermometer code

Behaviour:
- Reset (RST low, async): OUT=0, PENDING=0, SAT=0, ERR=0; EMPTY=1.
- Priority each rising edge: RST > CLR > EN.
- CLR=1: OUT<=0, PENDING<=0, SAT<=0, ERR<=0, regardless of EN.
- EN=0 (and CLR=0): OUT<=0, PENDING holds, SAT holds, ERR<=0. Inputs are ignored.
- EN=1:
  - inc = popcount(CARRY_IN), range 0..N_CARRY.
  - dec = 1 when OR_IN=0 and PENDING!=0; else 0.
  - OUT <= OR_IN | (PENDING!=0). At most one re-injected one per cycle; it uses only an idle cycle.
  - sum = PENDING + inc - dec, computed at width W_PEND+2, so no wrap is possible.
  - If sum > 2^W_PEND-1: PENDING <= 2^W_PEND-1 and SAT <= 1. Otherwise PENDING <= sum.
  - ERR <= 1 when CARRY_IN is not of form 0..01..1 (a higher bit set with a lower bit clear). The count still uses popcount.
- Latency: 1 cycle from OR_IN/CARRY_IN to OUT. A carry arriving in cycle t can be emitted no earlier than cycle t+1's input slot, so OUT at edge t+2.
- Simultaneous inc and dec in the same cycle: both apply (net inc-1).
- Full counter: if dec=1 in the same cycle, only the dec drains, so PENDING becomes max-1+inc, then saturates. SAT sets only when a carry is actually dropped.
- Empty counter with OR_IN=0: OUT<=0, no underflow, dec=0.
- N_CARRY=0 is not supported; elaboration error.
- Mid-stream RST/CLR discards all pending carries. This is intended; no drain required.

Decomposition:
- Shared stochastic package holds:
  - the thermometer-validity function;
  - the popcount function (parameterised width);
  - the saturating-add constant helper (max value from W_PEND).
- One natural sub-module: stoch_therm_decode. It takes CARRY_IN and produces count[$clog2(N_CARRY+1)-1:0] plus the valid flag. It is combinational and reusable by other carry consumers.
- The counter, output register and flags stay in the top module.

Test Plan:
- Reset then EN=1, OR_IN=1, CARRY_IN=2'b00 for 5 cycles -> OUT=1 from edge 1, PENDING=0, EMPTY=1, SAT=0.
- One cycle OR_IN=1, CARRY_IN=2'b11, then OR_IN=0, CARRY_IN=0 for 4 cycles -> PENDING goes 2,1,0. OUT sequence is 1,1,1,0,0, so exactly 2 extra ones are emitted.
- Hold OR_IN=1, CARRY_IN=2'b11 for 9 cycles (W_PEND=4) -> PENDING saturates at 15 on cycle 8, SAT=1 sticky. A subsequent CLR gives PENDING=0, SAT=0, OUT=0.
- PENDING=3, then EN=0 for 4 cycles with random inputs -> OUT=0, PENDING stays 3. On re-enable with OR_IN=0, PENDING drains 3,2,1,0 and OUT=1 for 3 cycles.
- CARRY_IN=2'b10 with EN=1 -> ERR pulses 1 for one cycle and PENDING increments by 1. CARRY_IN=2'b01 -> ERR=0.
- PENDING=5, assert RST low asynchronously mid-cycle -> OUT, PENDING, SAT, ERR go to 0 immediately without a clock edge, and EMPTY=1.

Source files
------------

// File: rtl/stoch_carry_reinject_pkg.sv
// Shared helpers for stochastic carry consumers: thermometer validity,
// popcount and the saturating-counter ceiling.
package stoch_carry_reinject_pkg;

   // Widest bus the helper functions accept; callers zero-extend into this.
   localparam int unsigned FN_W = 32;

   function automatic int unsigned popcount(input logic [FN_W-1:0] v, input int unsigned w);
      int unsigned       n;
      logic [FN_W-1:0]   t;
      n = 0;
      t = v;
      for (int unsigned i = 0; i < FN_W; i++) begin
         if (i < w) begin
            n = n + 32'(t[0]);
         end
         t = t >> 1;
      end
      return n;
   endfunction

   // A valid code is 0..01..1 within the low w bits: adding one to it must
   // carry cleanly into a single power of two.
   function automatic logic is_therm(input logic [FN_W-1:0] v, input int unsigned w);
      logic [FN_W-1:0] mask;
      logic [FN_W-1:0] m;
      mask = (w >= FN_W) ? '1 : ((FN_W'(1) << w) - FN_W'(1));
      m    = v & mask;
      return ((m & (m + FN_W'(1))) == '0);
   endfunction

   function automatic int unsigned sat_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/stoch_therm_decode.sv
// Combinational thermometer-bus decoder: population count of the carry bus
// plus a flag that the bus is a legal 0..01..1 code.
module stoch_therm_decode
   import stoch_carry_reinject_pkg::*;
#(
   parameter int N_CARRY = 2,
   localparam int CNT_W  = $clog2(N_CARRY + 1)
) (
   input  logic [N_CARRY-1:0] carry,
   output logic [CNT_W-1:0]   count,
   output logic               valid
);

   if (N_CARRY < 1 || N_CARRY > int'(FN_W)) begin : g_bad_width
      $error("stoch_therm_decode: N_CARRY must be in 1..32");
   end

   logic [FN_W-1:0] carry_ext;

   for (genvar gi = 0; gi < int'(FN_W); gi++) begin : g_ext
      if (gi < N_CARRY) begin : g_bit
         assign carry_ext[gi] = carry[gi];
      end else begin : g_pad
         assign carry_ext[gi] = 1'b0;
      end
   end

   assign count = CNT_W'(popcount(carry_ext, N_CARRY));
   assign valid = is_therm(carry_ext, N_CARRY);

endmodule

// File: rtl/stoch_carry_reinject.sv
// Re-injects carries lost by a cascaded-OR stochastic adder: banks them in a
// saturating counter and spends one per idle (OR-sum = 0) cycle.
module stoch_carry_reinject
   import stoch_carry_reinject_pkg::*;
#(
   parameter int N_CARRY = 2,
   parameter int W_PEND  = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               EN,
   input  logic               CLR,
   input  logic               OR_IN,
   input  logic [N_CARRY-1:0] CARRY_IN,
   output logic               OUT,
   output logic [W_PEND-1:0]  PENDING,
   output logic               EMPTY,
   output logic               SAT,
   output logic               ERR
);

   localparam int CNT_W = $clog2(N_CARRY + 1);
   // Two guard bits above the wider operand so pending + inc never wraps.
   localparam int SUM_W = ((CNT_W > W_PEND) ? CNT_W : W_PEND) + 2;
   localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'(sat_max(W_PEND));

   if (W_PEND < 1 || W_PEND > 30) begin : g_bad_pend
      $error("stoch_carry_reinject: W_PEND must be in 1..30");
   end

   logic [CNT_W-1:0]  inc;
   logic              code_valid;
   logic              dec;
   logic              have_pend;
   logic [SUM_W-1:0]  sum;
   logic              over;

   logic              out_reg,  out_next;
   logic [W_PEND-1:0] pend_reg, pend_next;
   logic              sat_reg,  sat_next;
   logic              err_reg,  err_next;

   stoch_therm_decode #(
      .N_CARRY (N_CARRY)
   ) u_decode (
      .carry (CARRY_IN),
      .count (inc),
      .valid (code_valid)
   );

   assign have_pend = (pend_reg != '0);
   assign dec       = ~OR_IN & have_pend;
   assign sum       = SUM_W'(pend_reg) + SUM_W'(inc) - SUM_W'(dec);
   assign over      = (sum > PEND_MAX);

   always_comb begin
      out_next  = 1'b0;
      pend_next = pend_reg;
      sat_next  = sat_reg;
      err_next  = 1'b0;
      if (CLR) begin
         pend_next = '0;
         sat_next  = 1'b0;
      end else if (EN) begin
         out_next  = OR_IN | have_pend;
         err_next  = ~code_valid;
         if (over) begin
            pend_next = W_PEND'(PEND_MAX);
            sat_next  = 1'b1;
         end else begin
            pend_next = W_PEND'(sum);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         out_reg  <= 1'b0;
         pend_reg <= '0;
         sat_reg  <= 1'b0;
         err_reg  <= 1'b0;
      end else begin
         out_reg  <= out_next;
         pend_reg <= pend_next;
         sat_reg  <= sat_next;
         err_reg  <= err_next;
      end
   end

   assign OUT     = out_reg;
   assign PENDING = pend_reg;
   assign EMPTY   = ~have_pend;
   assign SAT     = sat_reg;
   assign ERR     = err_reg;

endmodule

// File: tb/tb_stoch_carry_reinject.sv
// Bench for stoch_carry_reinject: directed vector table, hand-written corner
// sequences and a randomized run against a counting reference model.
module tb_stoch_carry_reinject;

   localparam int N_CARRY = 2;
   localparam int W_PEND  = 4;
   localparam int MAXP    = (1 << W_PEND) - 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               en;
   logic               clr;
   logic               or_in;
   logic [N_CARRY-1:0] carry_in;
   logic               out_bit;
   logic [W_PEND-1:0]  pending;
   logic               empty;
   logic               sat;
   logic               err;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model state: plain integers for the bank of owed ones.
   int m_out, m_pend, m_sat, m_err;

   typedef struct {
      logic       en;
      logic       clr;
      logic       or_in;
      logic [1:0] carry;
      int         e_out;
      int         e_pend;
      int         e_sat;
      int         e_err;
   } vec_t;

   vec_t vecs[$];

   stoch_carry_reinject #(
      .N_CARRY (N_CARRY),
      .W_PEND  (W_PEND)
   ) dut (
      .CLK      (clk),
      .RST      (rst_n),
      .EN       (en),
      .CLR      (clr),
      .OR_IN    (or_in),
      .CARRY_IN (carry_in),
      .OUT      (out_bit),
      .PENDING  (pending),
      .EMPTY    (empty),
      .SAT      (sat),
      .ERR      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out = 0; m_pend = 0; m_sat = 0; m_err = 0;
   endtask

   // Every owed carry is counted; one is repaid per cycle whose OR-sum is 0.
   task automatic model_step(input logic e, input logic c, input logic o, input logic [1:0] cy);
      int inc, dec, s;
      if (c) begin
         model_reset();
      end else if (!e) begin
         m_out = 0;
         m_err = 0;
      end else begin
         inc   = $countones(cy);
         dec   = (!o && m_pend > 0) ? 1 : 0;
         m_out = (o || m_pend > 0) ? 1 : 0;
         m_err = (int'(cy) == (1 << inc) - 1) ? 0 : 1;
         s     = m_pend + inc - dec;
         if (s > MAXP) begin
            m_pend = MAXP;
            m_sat  = 1;
         end else begin
            m_pend = s;
         end
      end
   endtask

   // Drive at the falling edge, clock once, sample at the next falling edge.
   task automatic step(input logic e, input logic c, input logic o, input logic [1:0] cy);
      en = e; clr = c; or_in = o; carry_in = cy;
      @(posedge clk);
      model_step(e, c, o, cy);
      @(negedge clk);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".out"},   int'(out_bit), m_out);
      chk({tag, ".pend"},  int'(pending), m_pend);
      chk({tag, ".empty"}, int'(empty),   (m_pend == 0) ? 1 : 0);
      chk({tag, ".sat"},   int'(sat),     m_sat);
      chk({tag, ".err"},   int'(err),     m_err);
   endtask

   task automatic add_vec(input logic e, input logic c, input logic o, input logic [1:0] cy,
                          input int eo, input int ep, input int es, input int ee);
      vec_t v;
      v.en = e; v.clr = c; v.or_in = o; v.carry = cy;
      v.e_out = eo; v.e_pend = ep; v.e_sat = es; v.e_err = ee;
      vecs.push_back(v);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; or_in = 1'b0; carry_in = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset.out", int'(out_bit), 0);
      chk("reset.pend", int'(pending), 0);
      chk("reset.empty", int'(empty), 1);
      chk("reset.sat", int'(sat), 0);
      chk("reset.err", int'(err), 0);
      rst_n = 1'b1;

      // Directed table: pass-through, carry repayment, bad codes, clear.
      for (int i = 0; i < 5; i++) add_vec(1, 0, 1, 2'b00, 1, 0, 0, 0);
      add_vec(1, 0, 1, 2'b11, 1, 2, 0, 0);
      add_vec(1, 0, 0, 2'b00, 1, 1, 0, 0);
      add_vec(1, 0, 0, 2'b00, 1, 0, 0, 0);
      add_vec(1, 0, 0, 2'b00, 0, 0, 0, 0);
      add_vec(1, 0, 0, 2'b00, 0, 0, 0, 0);
      add_vec(1, 0, 1, 2'b10, 1, 1, 0, 1);
      add_vec(1, 0, 1, 2'b01, 1, 2, 0, 0);
      add_vec(1, 0, 0, 2'b00, 1, 1, 0, 0);
      add_vec(0, 0, 1, 2'b10, 0, 1, 0, 0);
      add_vec(1, 0, 0, 2'b00, 1, 0, 0, 0);
      add_vec(1, 0, 0, 2'b01, 0, 1, 0, 0);
      add_vec(1, 1, 1, 2'b11, 0, 0, 0, 0);
      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].clr, vecs[i].or_in, vecs[i].carry);
         chk($sformatf("vec%0d.out", i), int'(out_bit), vecs[i].e_out);
         chk($sformatf("vec%0d.pend", i), int'(pending), vecs[i].e_pend);
         chk($sformatf("vec%0d.sat", i), int'(sat), vecs[i].e_sat);
         chk($sformatf("vec%0d.err", i), int'(err), vecs[i].e_err);
      end

      // Saturation: +2 per cycle reaches 14 after 7, clips to 15 on the 8th.
      for (int i = 1; i <= 9; i++) begin
         step(1, 0, 1, 2'b11);
         chk($sformatf("satrun%0d.pend", i), int'(pending), (i <= 7) ? 2 * i : MAXP);
         chk($sformatf("satrun%0d.sat", i), int'(sat), (i <= 7) ? 0 : 1);
      end
      step(1, 0, 0, 2'b01);
      chk("full_drain_plus1.pend", int'(pending), MAXP);
      chk("full_drain_plus1.out", int'(out_bit), 1);
      step(0, 1, 1, 2'b11);
      chk("satclr.pend", int'(pending), 0);
      chk("satclr.sat", int'(sat), 0);
      chk("satclr.out", int'(out_bit), 0);

      // Hold with EN low, then drain three owed ones.
      step(1, 0, 1, 2'b11);
      step(1, 0, 1, 2'b01);
      chk("hold_pre.pend", int'(pending), 3);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1'($urandom), 2'($urandom));
         chk("hold.out", int'(out_bit), 0);
         chk("hold.pend", int'(pending), 3);
      end
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 2'b00);
         chk($sformatf("drain%0d.pend", i), int'(pending), (i < 3) ? 2 - i : 0);
         chk($sformatf("drain%0d.out", i), int'(out_bit), (i < 3) ? 1 : 0);
      end

      // Asynchronous reset with five carries owed, between clock edges.
      step(1, 0, 1, 2'b11);
      step(1, 0, 1, 2'b11);
      step(1, 0, 1, 2'b01);
      chk("areset_pre.pend", int'(pending), 5);
      #2 rst_n = 1'b0;
      #1;
      chk("areset.out", int'(out_bit), 0);
      chk("areset.pend", int'(pending), 0);
      chk("areset.empty", int'(empty), 1);
      chk("areset.sat", int'(sat), 0);
      chk("areset.err", int'(err), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized run against the reference model.
      for (int i = 0; i < 400; i++) begin
         logic e, c, o;
         logic [1:0] cy;
         e  = ($urandom_range(0, 9) != 0);
         c  = ($urandom_range(0, 49) == 0);
         o  = ($urandom_range(0, 2) != 0);
         cy = 2'($urandom_range(0, 3));
         if (i % 100 >= 60) o = ($urandom_range(0, 3) == 0);
         step(e, c, o, cy);
         chk_model($sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
